// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data memory: opcodes, access sizes, RAM window.
package mem_pkg;

  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;

  localparam int          DMEM_DEPTH = 3072;
  localparam logic [31:0] ADDR_LIMIT = 32'h0000_2FFF;

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_WORD,
    ACC_HALF,
    ACC_BYTE
  } acc_size_e;

  // Replicate the store operand across every lane it could land in, so the
  // byte enables alone decide which lanes are written.
  function automatic logic [31:0] lane_align(input acc_size_e size, input logic [31:0] data);
    logic [31:0] result;
    case (size)
      ACC_HALF: result = {2{data[15:0]}};
      ACC_BYTE: result = {4{data[7:0]}};
      default:  result = data;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/mem_byte_enable.sv
// Byte-enable and misalignment generation from access size and the low address bits.
module mem_byte_enable
  import mem_pkg::*;
(
  input  acc_size_e  size_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] be_o,
  output logic       misalign_o
);

  always_comb begin
    be_o       = 4'b0000;
    misalign_o = 1'b0;
    case (size_i)
      ACC_WORD: begin
        if (addr_lo_i == 2'b00) be_o = 4'b1111;
        else                    misalign_o = 1'b1;
      end
      ACC_HALF: begin
        if (addr_lo_i[0]) misalign_o = 1'b1;
        else              be_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      end
      ACC_BYTE: be_o = 4'b0001 << addr_lo_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_dmem.sv
// MEM-stage data memory: decode, byte enables, and sync-write / comb-read RAM.
// Optional write trace printing is enabled with `define DMEM_WRITE_TRACE_EN.
module mem_stage_dmem
  import mem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH
)(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] instr,
  input  logic [31:0] pc4,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        exc_in,
  output logic [31:0] rdata,
  output logic        mem_write,
  output logic [3:0]  be,
  output logic        ade,
  output logic        dm_we
);

  logic [31:0] mem_q [DEPTH];

  acc_size_e   size;
  logic [11:0] word_idx;
  logic        in_range;
  logic [31:0] aligned_data;
  logic [31:0] old_word;
  logic [31:0] wr_word_d;
  logic        unused_bits;

  assign unused_bits = ^{instr[25:0], pc4};

  always_comb begin
    size      = ACC_NONE;
    mem_write = 1'b0;
    case (instr[31:26])
      OP_SW:               begin size = ACC_WORD; mem_write = 1'b1; end
      OP_SH:               begin size = ACC_HALF; mem_write = 1'b1; end
      OP_SB:               begin size = ACC_BYTE; mem_write = 1'b1; end
      OP_LW:               size = ACC_WORD;
      OP_LH, OP_LHU:       size = ACC_HALF;
      OP_LB, OP_LBU:       size = ACC_BYTE;
      default: ;
    endcase
  end

  mem_byte_enable u_byte_enable (
    .size_i     (size),
    .addr_lo_i  (addr[1:0]),
    .be_o       (be),
    .misalign_o (ade)
  );

  assign word_idx = addr[13:2];
  assign in_range = (addr <= ADDR_LIMIT);
  assign dm_we    = mem_write & ~exc_in & ~ade & in_range;
  assign old_word = mem_q[word_idx];
  assign rdata    = in_range ? old_word : 32'h0;

  // Read-modify-write merge: only lanes with a byte enable take the new data.
  always_comb begin
    aligned_data = lane_align(size, wdata);
    wr_word_d    = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) wr_word_d[8*i +: 8] = aligned_data[8*i +: 8];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
    end else if (dm_we) begin
      mem_q[word_idx] <= wr_word_d;
    end
  end

`ifdef DMEM_WRITE_TRACE_EN
  always_ff @(posedge Clk) begin
    if (!Reset && dm_we)
      $display("%0t@%h: *%h <= %h", $time, pc4 - 32'd4, {addr[31:2], 2'b00}, wr_word_d);
  end
`endif

endmodule

// File: tb/tb_mem_stage_dmem.sv
// Scoreboard bench for mem_stage_dmem: directed cases then randomized traffic
// against a byte-level reference model of the RAM.
module tb_mem_stage_dmem;

  logic        Clk;
  logic        Reset;
  logic [31:0] instr;
  logic [31:0] pc4;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        exc_in;
  logic [31:0] rdata;
  logic        mem_write;
  logic [3:0]  be;
  logic        ade;
  logic        dm_we;

  mem_stage_dmem dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .instr     (instr),
    .pc4       (pc4),
    .addr      (addr),
    .wdata     (wdata),
    .exc_in    (exc_in),
    .rdata     (rdata),
    .mem_write (mem_write),
    .be        (be),
    .ade       (ade),
    .dm_we     (dm_we)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic        ade;
    logic        mw;
    logic        we;
  } expect_t;

  expect_t     sbq [$];
  logic [31:0] model [0:3071];
  int          total;
  int          bad;

  // Reference model: sizes in bytes and plain arithmetic on byte lanes.
  function automatic int access_bytes(input logic [5:0] op);
    case (op)
      6'h2B, 6'h23:        return 4;
      6'h29, 6'h21, 6'h25: return 2;
      6'h28, 6'h20, 6'h24: return 1;
      default:             return 0;
    endcase
  endfunction

  task automatic applyStimulus(input string tag, input logic rst, input logic [5:0] op,
                               input logic [31:0] a, input logic [31:0] wd, input logic ex);
    expect_t e;
    int      n;
    int      lo;
    logic    is_store;
    logic [31:0] w;
    @(posedge Clk);
    #1;
    Reset  = rst;
    instr  = {op, 26'h155_AAAA};
    pc4    = 32'h0040_0000 + ($urandom_range(0, 255) * 4);
    addr   = a;
    wdata  = wd;
    exc_in = ex;
    n        = access_bytes(op);
    lo       = int'(a % 4);
    is_store = (op == 6'h2B) || (op == 6'h29) || (op == 6'h28);
    e.tag    = tag;
    e.mw     = is_store;
    if (n == 0) begin
      e.be  = 4'b0000;
      e.ade = 1'b0;
    end else if (lo % n != 0) begin
      e.be  = 4'b0000;
      e.ade = 1'b1;
    end else begin
      e.be  = 4'(((1 << n) - 1) << lo);
      e.ade = 1'b0;
    end
    e.we    = is_store && !ex && !e.ade && (a <= 32'h0000_2FFF);
    e.rdata = (a <= 32'h0000_2FFF) ? model[a / 4] : 32'h0;
    sbq.push_back(e);
    if (rst) begin
      for (int i = 0; i < 3072; i++) model[i] = 32'h0;
    end else if (e.we) begin
      w = model[a / 4];
      for (int k = 0; k < n; k++) w[8*(lo+k) +: 8] = wd[8*k +: 8];
      model[a / 4] = w;
    end
  endtask

  task automatic checkOutput(input string tag, input string field,
                             input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s.%s got=%h want=%h", tag, field, got, want);
    end
  endtask

  always @(negedge Clk) begin
    if (sbq.size() > 0) begin
      expect_t e;
      e = sbq.pop_front();
      checkOutput(e.tag, "rdata",     rdata,             e.rdata);
      checkOutput(e.tag, "be",        {28'h0, be},       {28'h0, e.be});
      checkOutput(e.tag, "ade",       {31'h0, ade},      {31'h0, e.ade});
      checkOutput(e.tag, "mem_write", {31'h0, mem_write},{31'h0, e.mw});
      checkOutput(e.tag, "dm_we",     {31'h0, dm_we},    {31'h0, e.we});
    end
  end

  logic [5:0] ops [10] = '{6'h2B, 6'h29, 6'h28, 6'h23, 6'h21, 6'h25, 6'h20, 6'h24, 6'h00, 6'h0F};

  initial begin
    int          sel;
    logic [31:0] ra;
    total  = 0;
    bad    = 0;
    for (int i = 0; i < 3072; i++) model[i] = 32'h0;
    Reset  = 1'b1;
    instr  = 32'h0;
    pc4    = 32'h0;
    addr   = 32'h0;
    wdata  = 32'h0;
    exc_in = 1'b0;
    repeat (3) @(posedge Clk);

    applyStimulus("reset_rd",   1'b0, 6'h23, 32'h10,   32'h0,        1'b0);
    applyStimulus("sw_10",      1'b0, 6'h2B, 32'h10,   32'hDEADBEEF, 1'b0);
    applyStimulus("lw_10",      1'b0, 6'h23, 32'h10,   32'h0,        1'b0);
    applyStimulus("sw_base",    1'b0, 6'h2B, 32'h10,   32'h11223344, 1'b0);
    applyStimulus("sb_13",      1'b0, 6'h28, 32'h13,   32'h000000AA, 1'b0);
    applyStimulus("lw_after_sb",1'b0, 6'h23, 32'h10,   32'h0,        1'b0);
    applyStimulus("sh_12",      1'b0, 6'h29, 32'h12,   32'h00005566, 1'b0);
    applyStimulus("lw_after_sh",1'b0, 6'h23, 32'h10,   32'h0,        1'b0);
    applyStimulus("sh_11_ade",  1'b0, 6'h29, 32'h11,   32'h0000FFFF, 1'b0);
    applyStimulus("lw_unchg",   1'b0, 6'h23, 32'h10,   32'h0,        1'b0);
    applyStimulus("sw_3000",    1'b0, 6'h2B, 32'h3000, 32'hA5A5A5A5, 1'b0);
    applyStimulus("lw_3000",    1'b0, 6'h23, 32'h3000, 32'h0,        1'b0);
    applyStimulus("lw_0000",    1'b0, 6'h23, 32'h0,    32'h0,        1'b0);
    applyStimulus("sw_2ffc",    1'b0, 6'h2B, 32'h2FFC, 32'h5A5A5A5A, 1'b0);
    applyStimulus("lw_2ffc",    1'b0, 6'h23, 32'h2FFC, 32'h0,        1'b0);
    applyStimulus("sw_20_exc",  1'b0, 6'h2B, 32'h20,   32'h99999999, 1'b1);
    applyStimulus("lw_20",      1'b0, 6'h23, 32'h20,   32'h0,        1'b0);
    applyStimulus("lw_21_ade",  1'b0, 6'h23, 32'h21,   32'h0,        1'b0);
    applyStimulus("sw_40",      1'b0, 6'h2B, 32'h40,   32'hCAFEF00D, 1'b0);
    applyStimulus("rst_sw_40",  1'b1, 6'h2B, 32'h40,   32'h12345678, 1'b0);
    applyStimulus("lw_40",      1'b0, 6'h23, 32'h40,   32'h0,        1'b0);

    for (int t = 0; t < 400; t++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)      ra = $urandom_range(0, 127);
      else if (sel < 8) ra = 32'h2FC0 + $urandom_range(0, 127);
      else              ra = $urandom;
      applyStimulus("rand", ($urandom_range(0, 59) == 0), ops[$urandom_range(0, 9)],
                    ra, $urandom, ($urandom_range(0, 7) == 0));
    end

    for (int w = 0; w < 10 && sbq.size() > 0; w++) @(posedge Clk);
    if (sbq.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain pending=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
